// File: rtl/axi_arb_pkg.sv
// Shared types and constants for the two-master AXI4-Lite arbiter.
package axi_arb_pkg;
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_ADDR  = 3'd1,
    RD_DATA  = 3'd2,
    WR_ADDR  = 3'd3,
    WR_RESP  = 3'd4,
    ERR_RESP = 3'd5
  } arb_state_e;

  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam int unsigned TIMEOUT_DEF = 1024;
endpackage

// File: rtl/axi4_lite_if.sv
// AXI4-Lite bundle; modport s is the subordinate side, m the manager side.
interface axi4_lite_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic [AW-1:0]   awaddr;
  logic [2:0]      awprot;
  logic            awvalid, awready;
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] wstrb;
  logic            wvalid, wready;
  logic [1:0]      bresp;
  logic            bvalid, bready;
  logic [AW-1:0]   araddr;
  logic [2:0]      arprot;
  logic            arvalid, arready;
  logic [DW-1:0]   rdata;
  logic [1:0]      rresp;
  logic            rvalid, rready;

  modport s (
    input  awaddr, awprot, awvalid, output awready,
    input  wdata, wstrb, wvalid,    output wready,
    output bresp, bvalid,           input  bready,
    input  araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid,    input  rready
  );
  modport m (
    output awaddr, awprot, awvalid, input  awready,
    output wdata, wstrb, wvalid,    input  wready,
    input  bresp, bvalid,           output bready,
    output araddr, arprot, arvalid, input  arready,
    input  rdata, rresp, rvalid,    output rready
  );
endinterface

// File: rtl/axi_lite_arbiter_rr_arb2.sv
// Two-request round-robin picker; the port not served last wins a tie.
module rr_arb2 (
  input  logic       aclk,
  input  logic       areset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);
  logic last;

  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = last ? 2'b01 : 2'b10;
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset)                last <= 1'b1;
    else if (advance && |gnt)  last <= gnt[1];
  end
endmodule

// File: rtl/axi_lite_arbiter.sv
// Shares one AXI4-Lite master port between two upstream masters, one transaction at a time.
// Define AXI_ARB_TIMEOUT_EN to enable the watchdog that aborts hung transactions with SLVERR.
module axi_lite_arbiter
  import axi_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT   = TIMEOUT_DEF,
  parameter logic [31:0] ERR_RDATA = 32'hDEAD_BEEF
) (
  input  logic        aclk,
  input  logic        areset,
  axi4_lite_if.s      s0,
  axi4_lite_if.s      s1,
  axi4_lite_if.m      m,
  output logic [1:0]  grant,
  output logic        busy,
  output logic        timeout
);
  if (TIMEOUT < 2 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("axi_lite_arbiter: TIMEOUT must be in 2..65535");
  end

  arb_state_e       state;
  logic [1:0]       op_last;   // per port: 1 = last op was a write
  logic             op_wr, aw_done, w_done, abort;

  logic [1:0]       ar_v, aw_v, w_v, r_r, b_r, req_wr, req, pick;
  logic [1:0][31:0] ar_a, aw_a, w_d;
  logic [1:0][2:0]  ar_p, aw_p;
  logic [1:0][3:0]  w_s;
  logic             sel, pick_p, pick_wr;

  assign ar_v = {s1.arvalid, s0.arvalid};
  assign aw_v = {s1.awvalid, s0.awvalid};
  assign w_v  = {s1.wvalid,  s0.wvalid};
  assign r_r  = {s1.rready,  s0.rready};
  assign b_r  = {s1.bready,  s0.bready};
  assign ar_a = {s1.araddr,  s0.araddr};
  assign ar_p = {s1.arprot,  s0.arprot};
  assign aw_a = {s1.awaddr,  s0.awaddr};
  assign aw_p = {s1.awprot,  s0.awprot};
  assign w_d  = {s1.wdata,   s0.wdata};
  assign w_s  = {s1.wstrb,   s0.wstrb};

  assign req_wr = aw_v & w_v;
  assign req    = ar_v | req_wr;
  assign sel    = grant[1];
  assign busy   = (state != IDLE);

  rr_arb2 u_rr (
    .aclk    (aclk),
    .areset  (areset),
    .req     (req),
    .advance (state == IDLE),
    .gnt     (pick)
  );

  // A port with both read and write pending takes the op it did not take last time.
  assign pick_p  = pick[1];
  assign pick_wr = req_wr[pick_p] && (!ar_v[pick_p] || !op_last[pick_p]);

  // Downstream drive
  assign m.araddr  = ar_a[sel];
  assign m.arprot  = ar_p[sel];
  assign m.arvalid = (state == RD_ADDR) && !abort;
  assign m.awaddr  = aw_a[sel];
  assign m.awprot  = aw_p[sel];
  assign m.awvalid = (state == WR_ADDR) && !aw_done && !abort;
  assign m.wdata   = w_d[sel];
  assign m.wstrb   = w_s[sel];
  assign m.wvalid  = (state == WR_ADDR) && !w_done && !abort;
  // Ready held high in IDLE so late responses after an abort drain away.
  assign m.rready  = (state == IDLE) || ((state == RD_DATA) && r_r[sel] && !abort);
  assign m.bready  = (state == IDLE) || ((state == WR_RESP) && b_r[sel] && !abort);

  logic ar_hs, aw_hs, w_hs, r_hs, b_hs, err_hs;
  assign ar_hs  = m.arvalid && m.arready;
  assign aw_hs  = m.awvalid && m.awready;
  assign w_hs   = m.wvalid  && m.wready;
  assign r_hs   = (state == RD_DATA) && m.rvalid && m.rready;
  assign b_hs   = (state == WR_RESP) && m.bvalid && m.bready;
  assign err_hs = (state == ERR_RESP) && (op_wr ? b_r[sel] : r_r[sel]);

  // Upstream drive, gated by ownership
  logic [1:0]       up_arready, up_awready, up_wready, up_rvalid, up_bvalid;
  logic [1:0][31:0] up_rdata;
  logic [1:0][1:0]  up_rresp, up_bresp;

  for (genvar i = 0; i < 2; i++) begin : g_up
    assign up_arready[i] = grant[i] && ar_hs;
    assign up_awready[i] = grant[i] && aw_hs;
    assign up_wready[i]  = grant[i] && w_hs;
    assign up_rvalid[i]  = grant[i] && (((state == RD_DATA) && m.rvalid && !abort) ||
                                        ((state == ERR_RESP) && !op_wr));
    assign up_bvalid[i]  = grant[i] && (((state == WR_RESP) && m.bvalid && !abort) ||
                                        ((state == ERR_RESP) && op_wr));
    assign up_rdata[i]   = !grant[i] ? '0 : (state == ERR_RESP) ? ERR_RDATA : m.rdata;
    assign up_rresp[i]   = !grant[i] ? RESP_OKAY : (state == ERR_RESP) ? RESP_SLVERR : m.rresp;
    assign up_bresp[i]   = !grant[i] ? RESP_OKAY : (state == ERR_RESP) ? RESP_SLVERR : m.bresp;
  end

  assign s0.arready = up_arready[0];  assign s1.arready = up_arready[1];
  assign s0.awready = up_awready[0];  assign s1.awready = up_awready[1];
  assign s0.wready  = up_wready[0];   assign s1.wready  = up_wready[1];
  assign s0.rvalid  = up_rvalid[0];   assign s1.rvalid  = up_rvalid[1];
  assign s0.rdata   = up_rdata[0];    assign s1.rdata   = up_rdata[1];
  assign s0.rresp   = up_rresp[0];    assign s1.rresp   = up_rresp[1];
  assign s0.bvalid  = up_bvalid[0];   assign s1.bvalid  = up_bvalid[1];
  assign s0.bresp   = up_bresp[0];    assign s1.bresp   = up_bresp[1];

`ifdef AXI_ARB_TIMEOUT_EN
  localparam logic [15:0] TO_LIM = 16'(TIMEOUT - 1);
  logic [15:0] cnt;

  assign abort = (state != IDLE) && (state != ERR_RESP) && (cnt == TO_LIM);

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      cnt     <= '0;
      timeout <= 1'b0;
    end else begin
      timeout <= abort;
      if (state == IDLE) cnt <= '0;
      else               cnt <= cnt + 16'd1;
    end
  end
`else
  assign abort   = 1'b0;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state   <= IDLE;
      grant   <= 2'b00;
      op_last <= 2'b00;
      op_wr   <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else if (abort) begin
      state   <= ERR_RESP;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (|pick) begin
          grant           <= pick;
          op_wr           <= pick_wr;
          op_last[pick_p] <= pick_wr;
          state           <= pick_wr ? WR_ADDR : RD_ADDR;
        end
        RD_ADDR: if (ar_hs) state <= RD_DATA;
        RD_DATA: if (r_hs) begin
          state <= IDLE;
          grant <= 2'b00;
        end
        WR_ADDR: begin
          // AW and W may complete in either order; leave once both are done.
          if ((aw_done || aw_hs) && (w_done || w_hs)) begin
            state   <= WR_RESP;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
          end else begin
            aw_done <= aw_done || aw_hs;
            w_done  <= w_done  || w_hs;
          end
        end
        WR_RESP: if (b_hs) begin
          state <= IDLE;
          grant <= 2'b00;
        end
        ERR_RESP: if (err_hs) begin
          state <= IDLE;
          grant <= 2'b00;
        end
        default: begin
          state <= IDLE;
          grant <= 2'b00;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_axi_lite_arbiter.sv
// Directed bench for axi_lite_arbiter; the slave side of m is scripted cycle by cycle.
module tb_axi_lite_arbiter;
  logic       aclk = 1'b0;
  logic       areset;
  logic [1:0] grant;
  logic       busy, timeout;
  int         n_tests = 0;
  int         n_fail  = 0;
  int         m_aw_hs = 0, m_w_hs = 0, s1_act = 0;

  axi4_lite_if s0_if ();
  axi4_lite_if s1_if ();
  axi4_lite_if m_if  ();

  axi_lite_arbiter #(.TIMEOUT(8), .ERR_RDATA(32'hDEAD_BEEF)) dut (
    .aclk    (aclk),
    .areset  (areset),
    .s0      (s0_if),
    .s1      (s1_if),
    .m       (m_if),
    .grant   (grant),
    .busy    (busy),
    .timeout (timeout)
  );

  always #5 aclk = ~aclk;

  always @(posedge aclk) begin
    if (m_if.awvalid && m_if.awready) m_aw_hs++;
    if (m_if.wvalid && m_if.wready)   m_w_hs++;
    if (s1_if.arready || s1_if.awready || s1_if.wready || s1_if.rvalid || s1_if.bvalid) s1_act++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic clear_inputs();
    s0_if.awaddr = '0; s0_if.awprot = '0; s0_if.awvalid = 0; s0_if.wdata = '0; s0_if.wstrb = '0;
    s0_if.wvalid = 0;  s0_if.bready = 0;  s0_if.araddr = '0;  s0_if.arprot = '0; s0_if.arvalid = 0;
    s0_if.rready = 0;
    s1_if.awaddr = '0; s1_if.awprot = '0; s1_if.awvalid = 0; s1_if.wdata = '0; s1_if.wstrb = '0;
    s1_if.wvalid = 0;  s1_if.bready = 0;  s1_if.araddr = '0;  s1_if.arprot = '0; s1_if.arvalid = 0;
    s1_if.rready = 0;
    m_if.awready = 0; m_if.wready = 0; m_if.bresp = '0; m_if.bvalid = 0;
    m_if.arready = 0; m_if.rdata = '0; m_if.rresp = '0; m_if.rvalid = 0;
  endtask

  task automatic do_reset();
    areset = 1'b1;
    clear_inputs();
    tick();
    tick();
    areset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base;
    areset = 1'b1;
    clear_inputs();
    tick(); tick();
    // reset state
    chk("rst_grant", grant, 2'b00);
    chk("rst_busy", busy, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_m_valids", {m_if.arvalid, m_if.awvalid, m_if.wvalid}, 3'b000);
    chk("rst_up_ready", {s0_if.arready, s0_if.awready, s0_if.wready, s1_if.arready}, 4'b0000);
    chk("rst_idle_rready", {m_if.rready, m_if.bready}, 2'b11);
    areset = 1'b0;

    // s0 read with 3 AR stall cycles
    base = s1_act;
    s0_if.araddr = 32'h10; s0_if.arprot = 3'b010; s0_if.arvalid = 1; s0_if.rready = 1;
    tick(); #1;
    chk("t1_grant", grant, 2'b01);
    chk("t1_busy", busy, 1);
    chk("t1_m_arvalid", m_if.arvalid, 1);
    chk("t1_m_araddr", m_if.araddr, 32'h10);
    chk("t1_m_arprot", m_if.arprot, 3'b010);
    chk("t1_stall_arready", s0_if.arready, 0);
    tick(); tick(); tick();
    m_if.arready = 1; #1;
    chk("t1_arready", s0_if.arready, 1);
    tick();
    s0_if.arvalid = 0; m_if.arready = 0;
    m_if.rvalid = 1; m_if.rdata = 32'h1234_5678; m_if.rresp = 2'b00; #1;
    chk("t1_m_arvalid_drop", m_if.arvalid, 0);
    chk("t1_rvalid", s0_if.rvalid, 1);
    chk("t1_rdata", s0_if.rdata, 32'h1234_5678);
    chk("t1_rresp", s0_if.rresp, 2'b00);
    chk("t1_grant_hold", grant, 2'b01);
    chk("t1_s1_rvalid", s1_if.rvalid, 0);
    tick();
    m_if.rvalid = 0; #1;
    chk("t1_done_busy", busy, 0);
    chk("t1_done_grant", grant, 2'b00);
    chk("t1_s1_quiet", s1_act - base, 0);

    // simultaneous reads alternate
    do_reset();
    s0_if.rready = 1; s1_if.rready = 1;
    s0_if.arvalid = 1; s1_if.arvalid = 1;
    for (int r = 0; r < 4; r++) begin
      tick(); #1;
      chk($sformatf("t2_grant_%0d", r), grant, (r % 2 == 0) ? 2'b01 : 2'b10);
      m_if.arready = 1;
      tick();
      if (r % 2 == 0) s0_if.arvalid = 0; else s1_if.arvalid = 0;
      m_if.arready = 0; m_if.rvalid = 1; m_if.rdata = 32'h100 + r; #1;
      chk($sformatf("t2_rdata_%0d", r), (r % 2 == 0) ? s0_if.rdata : s1_if.rdata, 32'h100 + r);
      chk($sformatf("t2_loser_rvalid_%0d", r), (r % 2 == 0) ? s1_if.rvalid : s0_if.rvalid, 0);
      tick();
      m_if.rvalid = 0;
      if (r % 2 == 0) s0_if.arvalid = 1; else s1_if.arvalid = 1;
    end

    // s1 write, W accepted 2 cycles before AW
    do_reset();
    base = m_aw_hs;
    s1_if.awaddr = 32'h20; s1_if.awvalid = 1; s1_if.wdata = 32'hA5A5_0F0F;
    s1_if.wstrb = 4'b0011; s1_if.wvalid = 1; s1_if.bready = 1;
    tick(); #1;
    chk("t3_grant", grant, 2'b10);
    chk("t3_aw_w_valid", {m_if.awvalid, m_if.wvalid}, 2'b11);
    chk("t3_awaddr", m_if.awaddr, 32'h20);
    chk("t3_wdata", m_if.wdata, 32'hA5A5_0F0F);
    chk("t3_wstrb", m_if.wstrb, 4'b0011);
    chk("t3_no_read", m_if.arvalid, 0);
    m_if.wready = 1; #1;
    chk("t3_wready", s1_if.wready, 1);
    tick();
    s1_if.wvalid = 0; m_if.wready = 0; #1;
    chk("t3_w_drop", {m_if.awvalid, m_if.wvalid}, 2'b10);
    tick();
    m_if.awready = 1;
    tick();
    s1_if.awvalid = 0; m_if.awready = 0;
    m_if.bvalid = 1; m_if.bresp = 2'b00; #1;
    chk("t3_aw_count", m_aw_hs - base, 1);
    chk("t3_w_count", m_w_hs - base, 1);
    chk("t3_bvalid", s1_if.bvalid, 1);
    chk("t3_bresp", s1_if.bresp, 2'b00);
    chk("t3_s0_bvalid", s0_if.bvalid, 0);
    tick();
    m_if.bvalid = 0; #1;
    chk("t3_done_busy", busy, 0);

    // s0 read+write pending: write, read, write
    do_reset();
    s0_if.arvalid = 1; s0_if.awvalid = 1; s0_if.wvalid = 1; s0_if.bready = 1; s0_if.rready = 1;
    tick(); #1;
    chk("t4_first_write", {m_if.awvalid, m_if.arvalid}, 2'b10);
    m_if.awready = 1; m_if.wready = 1;
    tick();
    s0_if.awvalid = 0; s0_if.wvalid = 0; m_if.awready = 0; m_if.wready = 0; m_if.bvalid = 1;
    tick();
    m_if.bvalid = 0; s0_if.awvalid = 1; s0_if.wvalid = 1;
    tick(); #1;
    chk("t4_then_read", {m_if.awvalid, m_if.arvalid}, 2'b01);
    m_if.arready = 1;
    tick();
    s0_if.arvalid = 0; m_if.arready = 0; m_if.rvalid = 1;
    tick();
    m_if.rvalid = 0; s0_if.arvalid = 1;
    tick(); #1;
    chk("t4_then_write", {m_if.awvalid, m_if.arvalid}, 2'b10);

    // hung slave
    do_reset();
    s0_if.arvalid = 1; s0_if.araddr = 32'h40; s0_if.rready = 1;
    s1_if.arvalid = 1; s1_if.araddr = 32'h44; s1_if.rready = 1;
    tick(); #1;
    chk("t5_grant", grant, 2'b01);
`ifdef AXI_ARB_TIMEOUT_EN
    for (int i = 1; i < 8; i++) begin
      tick(); #1;
      chk($sformatf("t5_no_timeout_%0d", i), timeout, 0);
    end
    chk("t5_valid_drop", m_if.arvalid, 0);
    tick(); #1;
    chk("t5_timeout_pulse", timeout, 1);
    chk("t5_err_rvalid", s0_if.rvalid, 1);
    chk("t5_err_rresp", s0_if.rresp, 2'b10);
    chk("t5_err_rdata", s0_if.rdata, 32'hDEAD_BEEF);
    chk("t5_s1_rvalid", s1_if.rvalid, 0);
    s0_if.arvalid = 0;
    tick(); #1;
    chk("t5_pulse_end", timeout, 0);
    chk("t5_idle", busy, 0);
    tick(); #1;
    chk("t5_s1_granted", grant, 2'b10);
`else
    for (int i = 0; i < 20; i++) tick();
    #1;
    chk("t5_hung_busy", busy, 1);
    chk("t5_hung_grant", grant, 2'b01);
    chk("t5_hung_arvalid", m_if.arvalid, 1);
    chk("t5_no_timeout", timeout, 0);
`endif

    // async reset during WR_RESP
    do_reset();
    s0_if.awaddr = 32'h30; s0_if.awvalid = 1; s0_if.wdata = 32'h55; s0_if.wstrb = 4'hF;
    s0_if.wvalid = 1; s0_if.bready = 1;
    tick();
    m_if.awready = 1; m_if.wready = 1;
    tick();
    s0_if.awvalid = 0; s0_if.wvalid = 0; m_if.awready = 0; m_if.wready = 0; m_if.bvalid = 1; #1;
    chk("t6_in_wr_resp", s0_if.bvalid, 1);
    areset = 1'b1; #1;
    chk("t6_rst_grant", grant, 2'b00);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_valids", {m_if.arvalid, m_if.awvalid, m_if.wvalid, s0_if.bvalid, s0_if.rvalid}, 5'b00000);
    m_if.bvalid = 0;
    tick();
    areset = 1'b0;
    s0_if.arvalid = 1; s1_if.arvalid = 1;
    tick(); #1;
    chk("t6_s0_wins", grant, 2'b01);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/axi_lite_arbiter.md
# axi_lite_arbiter

Two-master AXI4-Lite arbiter that shares the single register-bus master port between the PCIe bridge output and a second on-chip master, such as a local sequencer or debug master. It serves one transaction at a time with round-robin fairness between ports. It sits between the PCIe wrapper's `axi4_lite_if` master and the system register interconnect. An optional watchdog aborts transactions that the downstream slave never completes.

## Interface
- `TIMEOUT`, default 1024: watchdog limit in `aclk` cycles. Legal range is 2..65535. Used only with `AXI_ARB_TIMEOUT_EN`.
- `ERR_RDATA`, default 32'hDEAD_BEEF: `rdata` returned on an aborted read.
- `aclk`  in  1  single clock for all interfaces.
- `areset`  in  1  asynchronous, active-high reset.
- `s0`  `axi4_lite_if.s`  —  slave port 0 (PCIe side). Wins ties after reset.
- `s1`  `axi4_lite_if.s`  —  slave port 1 (local master).
- `m`  `axi4_lite_if.m`  —  shared downstream master port.
- `grant`  out  2  one-hot owner of the current transaction. 2'b00 when idle.
- `busy`  out  1  high from grant until the response handshake completes.
- `timeout`  out  1  one-cycle pulse on abort. Tied 0 when the macro is off.

## Operation
- FSM states:
  - IDLE
  - RD_ADDR
  - RD_DATA
  - WR_ADDR (AW and W in flight)
  - WR_RESP
  - ERR_RESP (macro only)
- Port request definitions:
  - Read request: `arvalid`.
  - Write request: `awvalid && wvalid`. A write is never granted on AW alone.
- Arbitration in IDLE:
  - Round-robin over the requesting ports, with priority pointer `last`.
  - The port not served last wins. `last` resets to 1, so s0 wins first.
  - `last` updates at grant.
- Read vs write within a port: a per-port `op_last` bit alternates when both are pending. It resets to read, so write goes first.
- Read path:
  - RD_ADDR drives `m.ar*` from the granted port and asserts `m.arvalid`.
  - The granted port's `arready` = `m.arready`.
  - On the AR handshake → RD_DATA.
  - `s*.r*` = `m.r*`, gated by `grant`. `m.rready` = the granted port's `rready`.
  - On the R handshake → IDLE.
- Write path:
  - WR_ADDR drives AW and W together. Sticky flags `aw_done` and `w_done` track each channel independently. A channel's `valid` drops once its handshake completes.
  - When both flags are set → WR_RESP.
  - B is passed through the same way as R. On the B handshake → IDLE.
- Non-granted port: all readys and valids held 0.
- Upstream ports see no address or data transformation. `prot`, `strb`, `addr` and `data` are passed through unchanged.
- Stray responses: `m.rready` and `m.bready` are held 1 in IDLE, so responses arriving after an abort are discarded.
- Reset values:
  - State IDLE.
  - `grant`=0, `busy`=0, `timeout`=0.
  - All `m` valids 0. All upstream readys and valids 0.
  - `last`=1, `op_last`=read, `aw_done`=0, `w_done`=0, watchdog counter 0.
- Reset mid-transaction: everything returns to reset values immediately (asynchronous). In-flight transactions are lost.

## Timing
- Grant is registered. A request first seen at edge N produces `m.arvalid`/`m.awvalid` during cycle N+1.
- Responses reach the upstream port combinationally, with zero added latency.
- Minimum read cost: 4 cycles — 1 grant + 1 AR + 1 R + 1 return to IDLE.
- Back-to-back: after a response completes, the next grant needs ≥1 IDLE cycle.
- Requests from both ports in the same cycle are resolved by `last` only.
- Upstream `valid` must stay asserted until accepted (AXI rule). The arbiter does not check this.

## Configuration
- `AXI_ARB_TIMEOUT_EN` defined:
  - A 16-bit counter clears at grant and increments every non-IDLE cycle.
  - When it reaches `TIMEOUT - 1`, all `m` valids drop and the state → ERR_RESP.
  - ERR_RESP returns `rresp`/`bresp` = SLVERR (2'b10) to the owner, with `rdata` = `ERR_RDATA` for reads. It holds `valid` until that port's `ready`, then → IDLE.
  - `timeout` pulses in the cycle ERR_RESP is entered.
- Macro undefined: no counter and no ERR_RESP; `timeout` is tied 0. A hung slave blocks both ports indefinitely.

## Structure
- `axi_arb_pkg`:
  - `arb_state_e` enum.
  - Response constants `RESP_OKAY`=2'b00 and `RESP_SLVERR`=2'b10.
  - Default `TIMEOUT`.
- Sub-module `rr_arb2`: 2-request round-robin picker with inputs `req[1:0]` and `advance`, and a one-hot `gnt` output. It holds the `last` register.
- Everything else, including the FSM and muxing, lives in the top module.

## Test plan
- s0 reads 0x10 while the slave returns 0x1234_5678 OKAY after 3 stall cycles → s0 gets `rdata`=0x1234_5678, `rresp`=0. s1 sees no handshakes. `grant`=01 throughout the transaction.
- s0 and s1 both assert `arvalid` in the same cycle, repeatedly → grants alternate 01, 10, 01, 10 in order.
- s1 writes 0x20 with `wstrb`=4'b0011; the slave accepts W 2 cycles before AW → exactly one AW and one W handshake on `m`, then `bresp` OKAY to s1.
- s0 holds both read and write requests → first a write, then a read, then a write (alternation via `op_last`).
- With `AXI_ARB_TIMEOUT_EN` and `TIMEOUT`=8, the slave never asserts `arready` → `timeout` pulses on cycle 8 after grant, s0 gets `rresp`=2'b10 and `rdata`=32'hDEAD_BEEF, then s1's pending request is granted.
- `areset` asserted during WR_RESP → `grant`, `busy` and all valids go 0 without waiting for a clock edge. After release, s0 wins the first arbitration.
